// File: rtl/async_fifo_rd_stream.sv
// async_fifo_rd_stream: read-domain drainer for the async FIFO.
// Pops the FIFO, absorbs its read latency, emits a framed valid/ready stream.
module async_fifo_rd_stream #(
  parameter int data_width = 8,
  parameter int BUF_DEPTH  = 4,
  parameter int BURST_LEN  = 16
) (
  input  logic                             rd_clk,
  input  logic                             rd_rst,
  input  logic                             enable,
  input  logic                             flush,
  input  logic                             fifo_empty,
  input  logic [data_width-1:0]            fifo_data,
  output logic                             fifo_rd_en,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [data_width-1:0]            m_data,
  output logic                             m_last,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   level,
  output logic [15:0]                      beat_cnt
);

  localparam int LW = $clog2(BUF_DEPTH+1);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam logic [15:0]   LAST_BEAT = 16'(BURST_LEN-1);
  localparam logic [LW:0]   DEPTH_W   = (LW+1)'(BUF_DEPTH);
  localparam logic [PW-1:0] PTR_MAX   = PW'(BUF_DEPTH-1);

  logic [data_width-1:0] r_mem [BUF_DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [LW-1:0]         r_level;
  logic                  r_pend;
  logic [15:0]           r_beat;

  logic [LW:0]   w_occ;
  logic          w_room;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic [PW-1:0] w_head_nxt;
  logic [PW-1:0] w_tail_nxt;

  // Occupancy counts the in-flight word so it always has a slot.
  assign w_valid    = (r_level != '0);
  assign w_occ      = {1'b0, r_level} + {{LW{1'b0}}, r_pend};
  assign w_room     = (w_occ < DEPTH_W);
  assign fifo_rd_en = enable & ~fifo_empty & ~flush & ~rd_rst & w_room;

  // A flush cycle neither captures nor transfers.
  assign w_push = r_pend & ~flush;
  assign w_pop  = w_valid & m_ready & ~flush;

  assign w_head_nxt = (r_head == PTR_MAX) ? '0 : r_head + PW'(1);
  assign w_tail_nxt = (r_tail == PTR_MAX) ? '0 : r_tail + PW'(1);

  assign m_valid  = w_valid;
  assign m_data   = w_valid ? r_mem[r_head] : '0;
  assign m_last   = w_valid & (r_beat == LAST_BEAT);
  assign level    = r_level;
  assign beat_cnt = r_beat;

  // Track the word whose data arrives one cycle after its pop.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= fifo_rd_en;
    end
  end

  // Circular buffer pointers and fill level.
  always_ff @(posedge rd_clk) begin
    if (rd_rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_tail <= w_tail_nxt;
      end
      if (w_pop) begin
        r_head <= w_head_nxt;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Capture the FIFO's registered read data into the tail slot.
  always_ff @(posedge rd_clk) begin
    if (w_push && !rd_rst) begin
      r_mem[r_tail] <= fifo_data;
    end
  end

  // Beat index within the burst, advancing on each transfer.
  always_ff @(posedge rd_clk) begin
    if (rd_rst || flush) begin
      r_beat <= '0;
    end else if (w_pop) begin
      r_beat <= (r_beat == LAST_BEAT) ? 16'd0 : r_beat + 16'd1;
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// tb_async_fifo_rd_stream: directed table, corner sequences and random
// traffic checked against a queue-based model of the stream drainer.
module tb_async_fifo_rd_stream;

  localparam int DEPTH = 4;
  localparam int BL    = 4;
  localparam int LW    = 3;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic          enable;
  logic          flush;
  logic          fifo_empty;
  logic [7:0]    fifo_data;
  logic          m_ready;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [7:0]    m_data;
  logic          m_last;
  logic [LW-1:0] level;
  logic [15:0]   beat_cnt;
  logic          o_rd;
  logic          o_valid;
  logic [7:0]    o_data;
  logic          o_last;
  logic [LW-1:0] o_level;
  logic [15:0]   o_beat;

  always #5 rd_clk = ~rd_clk;

  async_fifo_rd_stream #(
    .data_width(8), .BUF_DEPTH(DEPTH), .BURST_LEN(BL)
  ) u_dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable),
    .flush(flush), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .level(level), .beat_cnt(beat_cnt)
  );

  async_fifo_rd_stream #(
    .data_width(8), .BUF_DEPTH(DEPTH), .BURST_LEN(1)
  ) u_one (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable),
    .flush(flush), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_en(o_rd),
    .m_valid(o_valid), .m_ready(m_ready), .m_data(o_data),
    .m_last(o_last), .level(o_level), .beat_cnt(o_beat)
  );

  int n_tests;
  int n_fail;
  int rd_seen;
  bit chk_on;

  logic [7:0] fq[$];
  logic [7:0] mq[$];
  logic [7:0] got[$];
  bit         m_inf;
  logic [7:0] m_infw;
  int         m_beat;

  bit e_valid;
  bit e_rd;
  bit e_last;
  int e_data;
  int e_lvl;

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic settle();
    fifo_empty = (fq.size() == 0);
    #3;
    e_valid = (mq.size() != 0);
    e_data  = e_valid ? int'(mq[0]) : 0;
    e_lvl   = mq.size();
    e_last  = e_valid && (m_beat == BL-1);
    e_rd    = !rd_rst && enable && !fifo_empty && !flush &&
              (mq.size() + int'(m_inf) < DEPTH);
  endtask

  task automatic check_and_clock();
    bit xfer;
    logic [7:0] w;
    w = 8'h00;
    if (chk_on) begin
      chk("fifo_rd_en", fifo_rd_en, e_rd);
      chk("m_valid", m_valid, e_valid);
      chk("m_data", m_data, e_data);
      chk("m_last", m_last, e_last);
      chk("level", level, e_lvl);
      chk("beat_cnt", beat_cnt, m_beat);
      chk("bl1_rd_en", o_rd, e_rd);
      chk("bl1_valid", o_valid, e_valid);
      chk("bl1_data", o_data, e_data);
      chk("bl1_last", o_last, e_valid);
      chk("bl1_level", o_level, e_lvl);
      chk("bl1_beat", o_beat, 0);
    end
    if (fifo_rd_en) rd_seen++;
    xfer = e_valid && m_ready && !flush;
    @(posedge rd_clk);
    #1;
    if (e_rd) begin
      w = fq.pop_front();
      fifo_data = w;
    end
    if (rd_rst || flush) begin
      mq.delete();
      m_inf  = 1'b0;
      m_beat = 0;
    end else begin
      if (xfer) begin
        got.push_back(mq.pop_front());
        m_beat = (m_beat + 1) % BL;
      end
      if (m_inf) mq.push_back(m_infw);
      m_inf  = e_rd;
      m_infw = w;
    end
  endtask

  task automatic step();
    settle();
    check_and_clock();
  endtask

  task automatic do_reset();
    rd_rst = 1'b1;
    fq.delete();
    step();
    rd_rst = 1'b0;
    got.delete();
    rd_seen = 0;
  endtask

  task automatic push_seq(int n);
    for (int i = 1; i <= n; i++) fq.push_back(8'(i));
  endtask

  typedef struct {
    bit         en;
    bit         rdy;
    bit         fl;
    bit         x_rd;
    bit         x_valid;
    bit         x_last;
    logic [7:0] x_data;
    int         x_lvl;
  } vec_t;

  vec_t tbl[8];
  logic [7:0] lastw[$];
  bit found;

  initial begin
    tbl[0] = '{1, 1, 0, 1, 0, 0, 8'h00, 0};
    tbl[1] = '{1, 1, 0, 1, 0, 0, 8'h00, 0};
    tbl[2] = '{1, 1, 0, 1, 1, 0, 8'h01, 1};
    tbl[3] = '{1, 1, 0, 1, 1, 0, 8'h02, 1};
    tbl[4] = '{1, 1, 0, 1, 1, 0, 8'h03, 1};
    tbl[5] = '{1, 1, 0, 0, 1, 1, 8'h04, 1};
    tbl[6] = '{1, 1, 0, 0, 1, 0, 8'h05, 1};
    tbl[7] = '{1, 1, 0, 0, 0, 0, 8'h00, 0};

    n_tests = 0;
    n_fail  = 0;
    rd_seen = 0;
    chk_on  = 1'b0;
    m_inf   = 1'b0;
    m_infw  = 8'h00;
    m_beat  = 0;
    rd_rst  = 1'b1;
    enable  = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    fifo_data = 8'h00;
    @(posedge rd_clk);
    #1;
    step();
    chk_on = 1'b1;

    // reset state and basic 5-word drain, table driven
    do_reset();
    push_seq(5);
    for (int i = 0; i < 8; i++) begin
      enable  = tbl[i].en;
      m_ready = tbl[i].rdy;
      flush   = tbl[i].fl;
      settle();
      chk("tbl_rd_en", fifo_rd_en, tbl[i].x_rd);
      chk("tbl_valid", m_valid, tbl[i].x_valid);
      chk("tbl_data", m_data, tbl[i].x_data);
      chk("tbl_last", m_last, tbl[i].x_last);
      chk("tbl_level", level, tbl[i].x_lvl);
      check_and_clock();
    end
    chk("tbl_beat_end", beat_cnt, 1);
    chk("tbl_count", got.size(), 5);

    // burst framing over 8 words
    do_reset();
    push_seq(8);
    enable  = 1'b1;
    m_ready = 1'b1;
    lastw.delete();
    for (int i = 0; i < 14; i++) begin
      settle();
      if (m_valid && m_last) lastw.push_back(m_data);
      check_and_clock();
    end
    chk("burst_nlast", lastw.size(), 2);
    if (lastw.size() == 2) begin
      chk("burst_last0", lastw[0], 8'h04);
      chk("burst_last1", lastw[1], 8'h08);
    end
    chk("burst_beat_end", beat_cnt, 0);

    // backpressure
    do_reset();
    push_seq(10);
    enable  = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) step();
    settle();
    chk("bp_level", level, 4);
    chk("bp_rd_en", fifo_rd_en, 0);
    chk("bp_head", m_data, 8'h01);
    check_and_clock();
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("bp_count", got.size(), 10);
    for (int i = 0; i < got.size(); i++) chk("bp_order", got[i], i + 1);

    // enable drop after two pops
    do_reset();
    push_seq(10);
    enable  = 1'b1;
    m_ready = 1'b1;
    step();
    step();
    enable = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("en_pops", rd_seen, 2);
    chk("en_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("en_w0", got[0], 8'h01);
      chk("en_w1", got[1], 8'h02);
    end

    // flush with level=3 and a word in flight
    do_reset();
    push_seq(10);
    enable  = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    settle();
    chk("fl_pre_level", level, 3);
    chk("fl_pre_pops", rd_seen, 4);
    flush = 1'b1;
    settle();
    check_and_clock();
    flush = 1'b0;
    settle();
    chk("fl_valid", m_valid, 0);
    chk("fl_level", level, 0);
    chk("fl_beat", beat_cnt, 0);
    check_and_clock();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("fl_nonempty", int'(got.size() > 0), 1);
    if (got.size() > 0) chk("fl_next_word", got[0], 8'h05);

    // reset mid-burst at beat 2 with two buffered words
    do_reset();
    push_seq(12);
    enable = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      m_ready = (m_beat < 2);
      if (m_beat == 2 && mq.size() == 2) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("rst_reached", found, 1);
    chk("rst_pre_level", level, 2);
    chk("rst_pre_beat", beat_cnt, 2);
    rd_rst = 1'b1;
    settle();
    chk("rst_rd_en", fifo_rd_en, 0);
    check_and_clock();
    rd_rst = 1'b0;
    enable = 1'b0;
    settle();
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_level", level, 0);
    chk("rst_beat", beat_cnt, 0);
    check_and_clock();

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(2) == 0 && fq.size() < 64)
        fq.push_back(8'($urandom));
      enable  = ($urandom_range(7) != 0);
      m_ready = ($urandom_range(3) != 0);
      flush   = ($urandom_range(49) == 0);
      rd_rst  = ($urandom_range(199) == 0);
      step();
    end
    rd_rst = 1'b0;
    flush  = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
